timer_dev: RTL and testbench
============================

Name: timer_dev

Overview:
- Memory-mapped countdown timer peripheral on the CPU data bus.
- Acts as the responder for the processor's load/store data accesses.
- Decodes word address bits [3:2], accepts synchronous register writes and returns read data combinationally, in the same cycle as the access.
- Runs a preset/count state machine and raises a level interrupt request toward the CPU.

Parameters:
- WIDTH, 32, width of the data bus and of all timer registers.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- addr  input  2  word select, connected to CPU address bits [3:2].
- we  input  1  write enable (MemWr gated by the device-select decode).
- din  input  WIDTH  write data (rt register value).
- dout  output  WIDTH  read data, combinational from addr.
- irq  output  1  interrupt request, level-sensitive.

Behaviour:

Register map (word index):
- 0 = CTRL. Bit[0] EN; bits[2:1] MODE (00 one-shot, 01 auto-reload, 10/11 treated as 00); bit[3] IM, the interrupt mask (1 = irq enabled). Bits above 3 read as 0.
- 1 = PRESET, read/write.
- 2 = COUNT, read-only; writes are ignored.
- 3 = reserved; reads return 0 and writes are ignored.

Reset:
- CTRL=0, PRESET=0, COUNT=0, state=IDLE, pend=0.
- Consequently irq=0 and dout reflects the zeroed registers.
- Reset asserted mid-count aborts the count immediately, with no interrupt.

Writes:
- Captured at the rising edge when we=1.
- A software write to CTRL overrides any FSM update to CTRL in the same cycle.

Interrupt:
- irq = pend & CTRL.IM, combinational from registers.
- pend is set on entry to INT.
- pend is cleared by any write to CTRL or PRESET.
- If set and clear coincide, set wins.

FSM states: IDLE, LOAD, CNT, INT.
- IDLE: if EN=1, go to LOAD at the next edge; otherwise hold. COUNT holds.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT, evaluated in priority order:
  - EN=0: go to IDLE; COUNT frozen.
  - COUNT > 1: COUNT <= COUNT-1.
  - Otherwise (COUNT is 1 or 0): COUNT <= 0; go to INT; set pend.
- INT:
  - MODE=01: go to LOAD; EN stays 1.
  - Otherwise: clear CTRL.EN and go to IDLE.

Latency:
- EN written at edge N gives LOAD at N+1.
- COUNT=PRESET and state CNT at N+2.
- For PRESET=P>=1, COUNT reaches 0, state enters INT and irq rises at edge N+2+P.
- PRESET=0 behaves as PRESET=1: INT at N+3.
- Auto-reload period is P+2 cycles (INT, LOAD, then P CNT cycles).

Boundary conditions:
- A PRESET write during CNT does not disturb the running COUNT; it takes effect at the next LOAD.
- Clearing EN during CNT freezes COUNT one edge later. Re-enabling goes through LOAD, so COUNT restarts from PRESET rather than resuming.
- COUNT never wraps below 0.
- A WIDTH-bit PRESET of all ones counts 2^WIDTH-1 cycles without overflow.

Test Plan:
- Reset: assert rst mid-count with PRESET=5 -> all registers read 0, irq=0, state IDLE, without waiting for a clock edge.
- One-shot: write PRESET=3, then CTRL=0x9 (EN, IM, mode 00) at edge N -> COUNT reads 3,2,1,0 at edges N+2..N+5; irq=1 from N+5; CTRL reads 0x8 from N+6; irq holds until a CTRL write, and clears one edge after that write.
- Auto-reload: PRESET=2, CTRL=0xB -> irq rises every 4 cycles with COUNT sequence 2,1,0,0(INT),2,... Writing CTRL=0xB each period clears pend.
- Mask and stop: CTRL=0x1 with PRESET=4 -> on terminal count pend=1 but irq=0. Separately, writing CTRL=0x8 while COUNT=2 -> COUNT freezes at 2 or 1 as per the one-edge rule and no interrupt follows.
- Bus access: write 0xDEAD to addr 2 and to addr 3 -> COUNT unchanged and addr 3 reads 0. A PRESET write during CNT leaves the current count unaffected and is applied on the next reload.
- Corner values: PRESET=0 -> INT at N+3. Simultaneous CTRL write (EN=1, mode 00) on the INT edge -> software value wins and EN stays 1.

Source files
------------

// File: rtl/timer_dev_if.sv
// Data-bus port bundle between the CPU load/store path and the timer peripheral.
interface timer_dev_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic [1:0]       addr;
  logic             we;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             irq;

  modport master (
    output addr,
    output we,
    output din,
    input  dout,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  din,
    output dout,
    output irq
  );

endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, preset/count FSM
// and a level interrupt gated by the CTRL mask bit.
module timer_dev #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  timer_dev_if.slave  bus
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_AUTO   = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  state_e           state_q;
  state_e           state_d;

  logic             en_q;
  logic [1:0]       mode_q;
  logic             im_q;
  logic [WIDTH-1:0] preset_q;
  logic [WIDTH-1:0] count_q;
  logic             pend_q;

  logic             wr_ctrl_c;
  logic             wr_preset_c;
  logic             cnt_gt1_c;
  logic             auto_rl_c;

  logic             count_load_c;
  logic             count_dec_c;
  logic             count_zero_c;
  logic             pend_set_c;
  logic             en_clr_c;

  assign wr_ctrl_c   = bus.we && (bus.addr == ADDR_CTRL);
  assign wr_preset_c = bus.we && (bus.addr == ADDR_PRESET);
  assign cnt_gt1_c   = count_q > WIDTH'(1);
  assign auto_rl_c   = mode_q == MODE_AUTO;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (!cnt_gt1_c) begin
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        state_d = auto_rl_c ? ST_LOAD : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM actions on the datapath; COUNT of 0 or 1 both terminate so it never wraps
  always_comb begin
    count_load_c = 1'b0;
    count_dec_c  = 1'b0;
    count_zero_c = 1'b0;
    pend_set_c   = 1'b0;
    en_clr_c     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        count_load_c = 1'b1;
      end
      ST_CNT: begin
        if (en_q) begin
          if (cnt_gt1_c) begin
            count_dec_c = 1'b1;
          end else begin
            count_zero_c = 1'b1;
            pend_set_c   = 1'b1;
          end
        end
      end
      ST_INT: begin
        if (!auto_rl_c) en_clr_c = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // CTRL: software write beats the one-shot EN clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      mode_q <= 2'b00;
      im_q   <= 1'b0;
    end else if (wr_ctrl_c) begin
      en_q   <= bus.din[0];
      mode_q <= bus.din[2:1];
      im_q   <= bus.din[3];
    end else if (en_clr_c) begin
      en_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preset_q <= '0;
    end else if (wr_preset_c) begin
      preset_q <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (count_load_c) begin
      count_q <= preset_q;
    end else if (count_dec_c) begin
      count_q <= count_q - WIDTH'(1);
    end else if (count_zero_c) begin
      count_q <= '0;
    end
  end

  // Pending flag: terminal-count set wins over a same-cycle CTRL/PRESET write clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else if (pend_set_c) begin
      pend_q <= 1'b1;
    end else if (wr_ctrl_c || wr_preset_c) begin
      pend_q <= 1'b0;
    end
  end

  // Same-cycle read mux
  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      ADDR_CTRL:   bus.dout = WIDTH'({im_q, mode_q, en_q});
      ADDR_PRESET: bus.dout = preset_q;
      ADDR_COUNT:  bus.dout = count_q;
      default:     bus.dout = '0;
    endcase
  end

  assign bus.irq = pend_q & im_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed and random bench for timer_dev against an edge-timeline reference model.
module tb_timer_dev;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_dev_if #(.WIDTH(W)) bus ();

  timer_dev #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: register image plus the edge numbers at which the next
  // load and the terminal count fall.
  longint      t = 0;
  logic        m_en;
  logic [1:0]  m_mode;
  logic        m_im;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_pend;
  bit          m_active;
  longint      m_load_at;
  longint      m_term_at;

  logic [31:0] obs [4];

  function automatic void model_reset();
    m_en = 1'b0; m_mode = 2'b00; m_im = 1'b0;
    m_preset = '0; m_count = '0; m_pend = 1'b0;
    m_active = 1'b0; m_load_at = 0; m_term_at = 0;
  endfunction

  function automatic void model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
    logic        nen;
    logic [31:0] ncount;
    logic        nset;
    nen = m_en; ncount = m_count; nset = 1'b0;
    t++;
    if (!m_active) begin
      if (m_en) begin
        m_active  = 1'b1;
        m_load_at = t + 1;
      end
    end else if (t == m_load_at) begin
      ncount    = m_preset;
      m_term_at = t + ((m_preset == 32'd0) ? 64'd1 : longint'(m_preset));
    end else if (t <= m_term_at) begin
      if (!m_en) begin
        m_active = 1'b0;
      end else if (t == m_term_at) begin
        ncount = '0;
        nset   = 1'b1;
      end else begin
        ncount = m_count - 32'd1;
      end
    end else begin
      if (m_mode == 2'b01) begin
        m_load_at = t + 1;
      end else begin
        nen      = 1'b0;
        m_active = 1'b0;
      end
    end
    if (w && a == 2'd0) begin
      nen    = d[0];
      m_mode = d[2:1];
      m_im   = d[3];
    end
    if (w && a == 2'd1) m_preset = d;
    m_en    = nen;
    m_count = ncount;
    if (nset) m_pend = 1'b1;
    else if (w && (a == 2'd0 || a == 2'd1)) m_pend = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a);
      #1;
      obs[a] = bus.dout;
      chk($sformatf("%s_r%0d", tag, a), bus.dout, m_read(2'(a)));
    end
    chk({tag, "_irq"}, 32'(bus.irq), 32'(m_pend & m_im));
  endtask

  task automatic cycle(input logic w, input logic [1:0] a, input logic [31:0] d, input string tag);
    bus.we = w; bus.addr = a; bus.din = d;
    @(posedge clk);
    model_edge(w, a, d);
    #1;
    bus.we = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 2'd0, 32'd0, tag);
  endtask

  initial begin
    bus.we = 1'b0; bus.addr = 2'd0; bus.din = '0;
    rst = 1'b1;
    model_reset();
    #12;
    check_all("por");
    #5 rst = 1'b0;

    // One-shot, PRESET=3, CTRL=0x9 at edge N
    cycle(1'b1, 2'd1, 32'd3, "os_pre");
    cycle(1'b1, 2'd0, 32'h9, "os_en");
    idle("os_n1");
    idle("os_n2"); chk("os_cnt3", obs[2], 32'd3);
    idle("os_n3"); chk("os_cnt2", obs[2], 32'd2);
    idle("os_n4"); chk("os_cnt1", obs[2], 32'd1);
    idle("os_n5"); chk("os_cnt0", obs[2], 32'd0); chk("os_irq_hi", 32'(bus.irq), 32'd1);
    idle("os_n6"); chk("os_ctrl8", obs[0], 32'h8); chk("os_irq_hold", 32'(bus.irq), 32'd1);
    idle("os_n7");
    cycle(1'b1, 2'd0, 32'h8, "os_clr"); chk("os_irq_lo", 32'(bus.irq), 32'd0);

    // Auto-reload, PRESET=2, re-writing CTRL each period to clear pend
    cycle(1'b1, 2'd1, 32'd2, "ar_pre");
    cycle(1'b1, 2'd0, 32'hB, "ar_en");
    idle("ar_1"); idle("ar_2"); idle("ar_3");
    idle("ar_4"); chk("ar_irq0", 32'(bus.irq), 32'd1);
    for (int p = 0; p < 3; p++) begin
      cycle(1'b1, 2'd0, 32'hB, "ar_ack"); chk("ar_ack_lo", 32'(bus.irq), 32'd0);
      idle("ar_ld"); chk("ar_c2", obs[2], 32'd2);
      idle("ar_c"); chk("ar_c1", obs[2], 32'd1);
      idle("ar_t"); chk("ar_irq", 32'(bus.irq), 32'd1);
    end
    cycle(1'b1, 2'd0, 32'h0, "ar_off");
    for (int i = 0; i < 4; i++) idle("ar_drain");

    // Masked terminal count
    cycle(1'b1, 2'd1, 32'd4, "mk_pre");
    cycle(1'b1, 2'd0, 32'h1, "mk_en");
    for (int i = 0; i < 8; i++) idle("mk");
    chk("mk_irq_masked", 32'(bus.irq), 32'd0);
    cycle(1'b1, 2'd0, 32'h0, "mk_off");

    // Stop mid-count: CTRL=0x8 written while COUNT=2 freezes it at 1
    cycle(1'b1, 2'd1, 32'd5, "st_pre");
    cycle(1'b1, 2'd0, 32'h9, "st_en");
    for (int i = 0; i < 5; i++) idle("st_run");
    chk("st_pre2", obs[2], 32'd2);
    cycle(1'b1, 2'd0, 32'h8, "st_stop"); chk("st_frz", obs[2], 32'd1);
    for (int i = 0; i < 8; i++) idle("st_hold");
    chk("st_hold1", obs[2], 32'd1); chk("st_noirq", 32'(bus.irq), 32'd0);

    // Bus access: writes to COUNT/reserved ignored, PRESET write deferred to next load
    cycle(1'b1, 2'd1, 32'd6, "ba_pre");
    cycle(1'b1, 2'd0, 32'h9, "ba_en");
    idle("ba_1"); idle("ba_2"); idle("ba_3");
    cycle(1'b1, 2'd2, 32'hDEAD, "ba_wc"); chk("ba_cnt4", obs[2], 32'd4);
    cycle(1'b1, 2'd3, 32'hDEAD, "ba_wr"); chk("ba_cnt3", obs[2], 32'd3); chk("ba_rsv0", obs[3], 32'd0);
    cycle(1'b1, 2'd1, 32'd9, "ba_pw"); chk("ba_cnt2", obs[2], 32'd2);
    for (int i = 0; i < 4; i++) idle("ba_fin");
    cycle(1'b1, 2'd0, 32'h9, "ba_re");
    idle("ba_r1"); idle("ba_r2"); chk("ba_cnt9", obs[2], 32'd9);
    cycle(1'b1, 2'd0, 32'h0, "ba_off");
    for (int i = 0; i < 3; i++) idle("ba_drain");

    // PRESET=0 terminates at N+3; CTRL write on the INT edge keeps EN
    cycle(1'b1, 2'd1, 32'd0, "z_pre");
    cycle(1'b1, 2'd0, 32'h9, "z_en");
    idle("z_1"); idle("z_2"); chk("z_irq_lo", 32'(bus.irq), 32'd0);
    idle("z_3"); chk("z_irq_hi", 32'(bus.irq), 32'd1);
    cycle(1'b1, 2'd0, 32'h9, "z_sim"); chk("z_en_kept", obs[0], 32'h9);
    idle("z_5"); idle("z_6");
    idle("z_7"); chk("z_irq_again", 32'(bus.irq), 32'd1);
    cycle(1'b1, 2'd0, 32'h0, "z_off");
    idle("z_drain");

    // All-ones PRESET decrements without overflow
    cycle(1'b1, 2'd1, 32'hFFFF_FFFF, "big_pre");
    cycle(1'b1, 2'd0, 32'h1, "big_en");
    idle("big_1"); idle("big_2"); chk("big_load", obs[2], 32'hFFFF_FFFF);
    idle("big_3"); chk("big_dec", obs[2], 32'hFFFF_FFFE);
    cycle(1'b1, 2'd0, 32'h0, "big_off");
    idle("big_drain");

    // Async reset mid-count with PRESET=5
    cycle(1'b1, 2'd1, 32'd5, "rs_pre");
    cycle(1'b1, 2'd0, 32'h9, "rs_en");
    idle("rs_1"); idle("rs_2"); idle("rs_3");
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rs_async");
    chk("rs_cnt0", obs[2], 32'd0);
    #2 rst = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      w = ($urandom_range(0, 5) == 0);
      a = 2'($urandom_range(0, 3));
      case (a)
        2'd0:    d = 32'($urandom_range(0, 15));
        2'd1:    d = 32'($urandom_range(0, 6));
        default: d = $urandom;
      endcase
      cycle(w, a, d, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
